avl_master_port: RTL

- Avalon-MM initiator port that sits inside mips_cpu_bus, between the CPU core's simple memory request interface and the external Avalon bus.
- Converts a single-cycle core request into one Avalon read or write.
- Holds address, data and strobes stable while waitrequest is high.
- Returns a one-cycle response pulse with read data to the core.
- Counterpart to avl_slave_mem: this block drives the bus that the memory responds to.

---
 rtl/avl_master_port.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/avl_master_port.sv
// avl_master_port: Avalon-MM initiator between the CPU core's single-cycle
// memory request interface and the external Avalon bus. Each accepted core
// request becomes exactly one Avalon read or write. The bus outputs stay
// frozen while waitrequest is high, and completion returns a one-cycle
// resp_valid pulse carrying the read data.
//
// Optional feature, enabled by defining AVL_MASTER_ALIGN_CHECK_EN:
//   A full-word request (byteenable 4'b1111) whose byte address is not word
//   aligned is rejected. No bus cycle is issued; after one cycle in BUS the
//   block answers with resp_valid=1 and resp_err=1.
//   With the macro undefined, resp_err is constant 0 and address[1:0] is
//   simply masked, so the request is issued at the containing word.

module avl_master_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // core side
  input  logic                req,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_byteenable,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  // Avalon side
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                waitrequest
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  state_t            state_reg, state_next;

  logic              read_reg, read_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] writedata_reg, writedata_next;
  logic [BE_W-1:0]   byteenable_reg, byteenable_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [DATA_W-1:0] resp_rdata_reg, resp_rdata_next;
  logic              req_ready_reg, req_ready_next;

  // The request is taken only in IDLE; req is ignored while the bus is busy.
  logic              accept;
  // The transaction in BUS finishes at this edge.
  logic              bus_done;
  // The request at the inputs is a misaligned full-word access.
  logic              req_misaligned;

  assign accept = req && (state_reg == S_IDLE);

`ifdef AVL_MASTER_ALIGN_CHECK_EN
  logic resp_err_reg, resp_err_next;
  // The accepted request was rejected and never reached the bus.
  logic misalign_reg, misalign_next;

  assign req_misaligned = (req_addr[1:0] != 2'b00) && (req_byteenable == {BE_W{1'b1}});
  // A rejected request never waits on the bus, so it finishes after one cycle.
  assign bus_done       = misalign_reg || !waitrequest;
  assign resp_err       = resp_err_reg;
`else
  // The low address bits only matter to the alignment check. In this build
  // they are masked off.
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];
  assign req_misaligned  = 1'b0;
  assign bus_done        = !waitrequest;
  assign resp_err        = 1'b0;
`endif

  // State and registered outputs; reset aborts any bus cycle in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      address_reg    <= '0;
      writedata_reg  <= '0;
      byteenable_reg <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      req_ready_reg  <= 1'b1;
`ifdef AVL_MASTER_ALIGN_CHECK_EN
      resp_err_reg   <= 1'b0;
      misalign_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      read_reg       <= read_next;
      write_reg      <= write_next;
      address_reg    <= address_next;
      writedata_reg  <= writedata_next;
      byteenable_reg <= byteenable_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      req_ready_reg  <= req_ready_next;
`ifdef AVL_MASTER_ALIGN_CHECK_EN
      resp_err_reg   <= resp_err_next;
      misalign_reg   <= misalign_next;
`endif
    end
  end

  // Next state: IDLE -> BUS on an accepted request, BUS -> IDLE on completion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_BUS;
      S_BUS:   if (bus_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs. Bus fields hold unless they are
  // loaded at acceptance or dropped at completion.
  always_comb begin
    read_next       = read_reg;
    write_next      = write_reg;
    address_next    = address_reg;
    writedata_next  = writedata_reg;
    byteenable_next = byteenable_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    req_ready_next  = (state_next == S_IDLE);
`ifdef AVL_MASTER_ALIGN_CHECK_EN
    resp_err_next   = 1'b0;
    misalign_next   = misalign_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (req_misaligned) begin
            // Rejected: keep the bus quiet and remember to report an error.
            read_next  = 1'b0;
            write_next = 1'b0;
`ifdef AVL_MASTER_ALIGN_CHECK_EN
            misalign_next = 1'b1;
`endif
          end else begin
            read_next       = !req_write;
            write_next      = req_write;
            address_next    = {req_addr[ADDR_W-1:2], 2'b00};
            writedata_next  = req_wdata;
            byteenable_next = req_byteenable;
          end
        end
      end
      S_BUS: begin
        if (bus_done) begin
          read_next       = 1'b0;
          write_next      = 1'b0;
          resp_valid_next = 1'b1;
          // A read is still asserted at completion only for a real bus read.
          if (read_reg) resp_rdata_next = readdata;
`ifdef AVL_MASTER_ALIGN_CHECK_EN
          resp_err_next = misalign_reg;
          misalign_next = 1'b0;
`endif
        end
      end
      default: begin
        read_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign address    = address_reg;
  assign read       = read_reg;
  assign write      = write_reg;
  assign writedata  = writedata_reg;
  assign byteenable = byteenable_reg;

endmodule
